// File: rtl/rv32v_types_pkg.sv
// Shared types for the rv32v vector datapath.
//   vsew_t        element width encoding (SEW8/16/32 legal, SEW64 rejected)
//   vseq_state_t  uop sequencer FSM states
//   NUM_LANES     elements per micro-op, one per lane
//   VLENB         bytes per vector register
//   VLMAX         maximum elements per instruction
package rv32v_types_pkg;

   localparam int NUM_LANES = 4;
   localparam int VLENB     = 16;
   localparam int VLMAX     = 128;

   typedef enum logic [2:0] {
      SEW8  = 3'd0,
      SEW16 = 3'd1,
      SEW32 = 3'd2,
      SEW64 = 3'd3
   } vsew_t;

   typedef enum logic {
      VSEQ_IDLE,
      VSEQ_ISSUE
   } vseq_state_t;

   localparam logic [2:0] SEW_MAX_LEGAL = SEW32;

   function automatic logic sew_legal(input logic [2:0] sew);
      return sew <= SEW_MAX_LEGAL;
   endfunction

endpackage

// File: rtl/rv32v_uop_addr_gen.sv
// Combinational address/lane generator for one micro-op.
// Inputs : idx (first element index of the uop), vsew, vl, vstart, group bases.
// Outputs: vd/vs1/vs2 register selects, vbank_offset (word group inside the
//          register), vlaneactive (per-lane element mask), vuop_last.
module rv32v_uop_addr_gen
   import rv32v_types_pkg::*;
(
   input  logic [7:0]           idx,
   input  logic [2:0]           vsew,
   input  logic [7:0]           vl,
   input  logic [6:0]           vstart,
   input  logic [4:0]           vd_base,
   input  logic [4:0]           vs1_base,
   input  logic [4:0]           vs2_base,
   output logic [4:0]           vd_sel,
   output logic [4:0]           vs1_sel,
   output logic [4:0]           vs2_sel,
   output logic [1:0]           vbank_offset,
   output logic [NUM_LANES-1:0] vlaneactive,
   output logic                 vuop_last
);

   logic [4:0] reg_off;
   logic [8:0] elem;

   // A register holds 16/8/4 elements at SEW8/16/32; within it every
   // group of four elements is one bank word.
   always_comb begin
      reg_off      = '0;
      vbank_offset = '0;
      case (vsew)
         SEW8: begin
            reg_off      = {1'b0, idx[7:4]};
            vbank_offset = idx[3:2];
         end
         SEW16: begin
            reg_off      = idx[7:3];
            vbank_offset = {1'b0, idx[2]};
         end
         default: begin
            reg_off      = idx[6:2];
            vbank_offset = 2'd0;
         end
      endcase
   end

   // Selects wrap modulo 32 by construction of the 5-bit add.
   assign vd_sel  = vd_base  + reg_off;
   assign vs1_sel = vs1_base + reg_off;
   assign vs2_sel = vs2_base + reg_off;

   assign vuop_last = ({1'b0, idx} + 9'd4) >= {1'b0, vl};

   always_comb begin
      elem        = '0;
      vlaneactive = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         elem           = {1'b0, idx} + 9'(i);
         vlaneactive[i] = (elem >= {2'b00, vstart}) && (elem < {1'b0, vl});
      end
   end

endmodule

// File: rtl/rv32v_uop_sequencer.sv
// Cracks one accepted vector instruction into 4-element micro-ops.
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   flush              abort current instruction (highest priority)
//   instr_valid/ready  instruction handshake; ready only in IDLE
//   vl, vstart, vsew   vector length, first element, element width
//   vd/vs1/vs2_base    register group bases
//   uop_valid/ready    micro-op handshake
//   vuop_num, vuop_last, vlaneactive, vd/vs1/vs2_sel, vbank_offset
//                      registered micro-op fields, held while stalled
//   illegal            one-cycle pulse when an instruction with vsew>SEW32 is rejected
//
// state      | meaning
// VSEQ_IDLE  | waiting for an instruction, instr_ready=1
// VSEQ_ISSUE | presenting uops, advancing idx by 4 per handshake
module rv32v_uop_sequencer
   import rv32v_types_pkg::*;
(
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 flush,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [7:0]           vl,
   input  logic [6:0]           vstart,
   input  logic [2:0]           vsew,
   input  logic [4:0]           vd_base,
   input  logic [4:0]           vs1_base,
   input  logic [4:0]           vs2_base,
   output logic                 uop_valid,
   input  logic                 uop_ready,
   output logic [4:0]           vuop_num,
   output logic                 vuop_last,
   output logic [NUM_LANES-1:0] vlaneactive,
   output logic [4:0]           vd_sel,
   output logic [4:0]           vs1_sel,
   output logic [4:0]           vs2_sel,
   output logic [1:0]           vbank_offset,
   output logic                 illegal
);

   vseq_state_t state_q, state_d;

   logic [7:0] idx_q, vl_q;
   logic [6:0] vstart_q;
   logic [2:0] vsew_q;
   logic [4:0] vd_q, vs1_q, vs2_q;

   logic accept, reject, advance, finish, load;

   logic [7:0]           g_idx, g_vl;
   logic [6:0]           g_vstart;
   logic [2:0]           g_vsew;
   logic [4:0]           g_vd, g_vs1, g_vs2;
   logic [4:0]           g_vd_sel, g_vs1_sel, g_vs2_sel;
   logic [1:0]           g_bank;
   logic [NUM_LANES-1:0] g_lanes;
   logic                 g_last;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state_q <= VSEQ_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      reject  = 1'b0;
      advance = 1'b0;
      finish  = 1'b0;
      case (state_q)
         VSEQ_IDLE: begin
            if (instr_valid && !flush) begin
               if (sew_legal(vsew)) begin
                  accept  = 1'b1;
                  state_d = VSEQ_ISSUE;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         VSEQ_ISSUE: begin
            if (uop_ready && !flush) begin
               if (vuop_last) begin
                  finish  = 1'b1;
                  state_d = VSEQ_IDLE;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: state_d = VSEQ_IDLE;
      endcase
      if (flush) state_d = VSEQ_IDLE;
   end

   assign load = accept | advance;

   // The generator looks at the uop about to be registered: either the
   // first uop of a freshly accepted instruction or the next one.
   assign g_idx    = accept ? {1'b0, vstart[6:2], 2'b00} : idx_q + 8'd4;
   assign g_vl     = accept ? vl       : vl_q;
   assign g_vstart = accept ? vstart   : vstart_q;
   assign g_vsew   = accept ? vsew     : vsew_q;
   assign g_vd     = accept ? vd_base  : vd_q;
   assign g_vs1    = accept ? vs1_base : vs1_q;
   assign g_vs2    = accept ? vs2_base : vs2_q;

   rv32v_uop_addr_gen u_addr_gen (
      .idx          (g_idx),
      .vsew         (g_vsew),
      .vl           (g_vl),
      .vstart       (g_vstart),
      .vd_base      (g_vd),
      .vs1_base     (g_vs1),
      .vs2_base     (g_vs2),
      .vd_sel       (g_vd_sel),
      .vs1_sel      (g_vs1_sel),
      .vs2_sel      (g_vs2_sel),
      .vbank_offset (g_bank),
      .vlaneactive  (g_lanes),
      .vuop_last    (g_last)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         idx_q        <= '0;
         vl_q         <= '0;
         vstart_q     <= '0;
         vsew_q       <= '0;
         vd_q         <= '0;
         vs1_q        <= '0;
         vs2_q        <= '0;
         vuop_num     <= '0;
         vuop_last    <= 1'b0;
         vlaneactive  <= '0;
         vd_sel       <= '0;
         vs1_sel      <= '0;
         vs2_sel      <= '0;
         vbank_offset <= '0;
         illegal      <= 1'b0;
      end else if (flush || finish) begin
         idx_q        <= '0;
         vl_q         <= '0;
         vstart_q     <= '0;
         vsew_q       <= '0;
         vd_q         <= '0;
         vs1_q        <= '0;
         vs2_q        <= '0;
         vuop_num     <= '0;
         vuop_last    <= 1'b0;
         vlaneactive  <= '0;
         vd_sel       <= '0;
         vs1_sel      <= '0;
         vs2_sel      <= '0;
         vbank_offset <= '0;
         illegal      <= 1'b0;
      end else begin
         illegal <= reject;
         if (load) begin
            idx_q        <= g_idx;
            vl_q         <= g_vl;
            vstart_q     <= g_vstart;
            vsew_q       <= g_vsew;
            vd_q         <= g_vd;
            vs1_q        <= g_vs1;
            vs2_q        <= g_vs2;
            vuop_num     <= g_idx[6:2];
            vuop_last    <= g_last;
            vlaneactive  <= g_lanes;
            vd_sel       <= g_vd_sel;
            vs1_sel      <= g_vs1_sel;
            vs2_sel      <= g_vs2_sel;
            vbank_offset <= g_bank;
         end
      end
   end

   assign instr_ready = (state_q == VSEQ_IDLE);
   assign uop_valid   = (state_q == VSEQ_ISSUE);

endmodule

// File: tb/tb_rv32v_uop_sequencer.sv
module tb_rv32v_uop_sequencer;
   import rv32v_types_pkg::*;

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic       flush = 1'b0;
   logic       instr_valid = 1'b0;
   logic       uop_ready = 1'b1;
   logic [7:0] vl = '0;
   logic [6:0] vstart = '0;
   logic [2:0] vsew = '0;
   logic [4:0] vd_base = '0, vs1_base = '0, vs2_base = '0;
   logic       instr_ready, uop_valid, vuop_last, illegal;
   logic [4:0] vuop_num, vd_sel, vs1_sel, vs2_sel;
   logic [3:0] vlaneactive;
   logic [1:0] vbank_offset;

   rv32v_uop_sequencer dut (
      .CLK(CLK), .nRST(nRST), .flush(flush),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .vl(vl), .vstart(vstart), .vsew(vsew),
      .vd_base(vd_base), .vs1_base(vs1_base), .vs2_base(vs2_base),
      .uop_valid(uop_valid), .uop_ready(uop_ready),
      .vuop_num(vuop_num), .vuop_last(vuop_last), .vlaneactive(vlaneactive),
      .vd_sel(vd_sel), .vs1_sel(vs1_sel), .vs2_sel(vs2_sel),
      .vbank_offset(vbank_offset), .illegal(illegal)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [4:0] num;
      logic       last;
      logic [3:0] lanes;
      logic [4:0] vd;
      logic [4:0] vs1;
      logic [4:0] vs2;
      logic [1:0] bank;
   } uop_t;

   typedef struct {
      logic [7:0] vl;
      logic [6:0] vstart;
      logic [2:0] vsew;
      logic [4:0] vd, vs1, vs2;
      int         stall_uop;
      int         stall_cyc;
      int         exp_n;
      logic [4:0] exp_num_last;
      logic [3:0] exp_lanes_last;
      logic [4:0] exp_vd_last;
   } vec_t;

   uop_t exp_q[$];
   uop_t last_seen;
   uop_t held_snap;
   bit   held = 0;
   int   errors = 0;
   int   checks = 0;
   int   hs_count = 0;
   vec_t tbl[7];

   function automatic uop_t cur_uop();
      uop_t u;
      u.num = vuop_num; u.last = vuop_last; u.lanes = vlaneactive;
      u.vd = vd_sel; u.vs1 = vs1_sel; u.vs2 = vs2_sel; u.bank = vbank_offset;
      return u;
   endfunction

   function automatic vec_t mk(input int v_l, input int v_st, input logic [2:0] sew,
                               input int d, input int s1, input int s2,
                               input int st_u, input int st_c, input int n,
                               input int num_l, input logic [3:0] lanes_l, input int vd_l);
      vec_t t;
      t.vl = 8'(v_l); t.vstart = 7'(v_st); t.vsew = sew;
      t.vd = 5'(d); t.vs1 = 5'(s1); t.vs2 = 5'(s2);
      t.stall_uop = st_u; t.stall_cyc = st_c; t.exp_n = n;
      t.exp_num_last = 5'(num_l); t.exp_lanes_last = lanes_l; t.exp_vd_last = 5'(vd_l);
      return t;
   endfunction

   // Reference model: element index -> register/bank via elements-per-register.
   task automatic push_model(input vec_t t);
      int   idx, epr;
      uop_t u;
      idx = int'(t.vstart) & ~3;
      epr = VLENB >> int'(t.vsew);
      for (int k = 0; k < 40; k++) begin
         u.num  = 5'(idx / 4);
         u.last = (idx + 4 >= int'(t.vl));
         for (int i = 0; i < 4; i++)
            u.lanes[i] = (idx + i >= int'(t.vstart)) && (idx + i < int'(t.vl));
         u.vd   = 5'((int'(t.vd)  + idx / epr) % 32);
         u.vs1  = 5'((int'(t.vs1) + idx / epr) % 32);
         u.vs2  = 5'((int'(t.vs2) + idx / epr) % 32);
         u.bank = 2'((idx % epr) / 4);
         exp_q.push_back(u);
         if (u.last) break;
         idx += 4;
      end
   endtask

   always @(negedge CLK) begin
      uop_t c, e;
      c = cur_uop();
      if (uop_valid && held) begin
         checks++;
         if (c !== held_snap) begin
            errors++;
            $display("FAIL hold: got num=%0d vd=%0d bank=%0d lanes=%b want num=%0d vd=%0d bank=%0d lanes=%b",
                     c.num, c.vd, c.bank, c.lanes, held_snap.num, held_snap.vd, held_snap.bank, held_snap.lanes);
         end
      end
      held = uop_valid && !uop_ready;
      held_snap = c;
      if (uop_valid && uop_ready) begin
         hs_count++;
         last_seen = c;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL uop_unexpected: got num=%0d vd=%0d want no uop", c.num, c.vd);
         end else begin
            e = exp_q.pop_front();
            if (c !== e) begin
               errors++;
               $display("FAIL uop: got num=%0d last=%0b lanes=%b vd=%0d vs1=%0d vs2=%0d bank=%0d want num=%0d last=%0b lanes=%b vd=%0d vs1=%0d vs2=%0d bank=%0d",
                        c.num, c.last, c.lanes, c.vd, c.vs1, c.vs2, c.bank,
                        e.num, e.last, e.lanes, e.vd, e.vs1, e.vs2, e.bank);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic drive_instr(input vec_t t);
      vl = t.vl; vstart = t.vstart; vsew = t.vsew;
      vd_base = t.vd; vs1_base = t.vs1; vs2_base = t.vs2;
      instr_valid = 1'b1;
   endtask

   task automatic run_instr(input vec_t t, input string name);
      int g, hs0;
      g = 0;
      while (!instr_ready && g < 50) begin @(posedge CLK); #1; g++; end
      check({name, "_ready_before"}, int'(instr_ready), 1);
      push_model(t);
      hs0 = hs_count;
      drive_instr(t);
      @(posedge CLK); #1;
      instr_valid = 1'b0;
      if (t.stall_cyc > 0) begin
         repeat (t.stall_uop) @(posedge CLK);
         #1 uop_ready = 1'b0;
         repeat (t.stall_cyc) @(posedge CLK);
         #1 uop_ready = 1'b1;
      end
      g = 0;
      while ((exp_q.size() != 0 || !instr_ready) && g < 200) begin @(posedge CLK); #1; g++; end
      check({name, "_done_in_budget"}, int'(exp_q.size() == 0 && instr_ready), 1);
      exp_q.delete();
      check({name, "_uop_count"}, hs_count - hs0, t.exp_n);
      check({name, "_last_num"}, int'(last_seen.num), int'(t.exp_num_last));
      check({name, "_last_lanes"}, int'(last_seen.lanes), int'(t.exp_lanes_last));
      check({name, "_last_vd"}, int'(last_seen.vd), int'(t.exp_vd_last));
      check({name, "_last_flag"}, int'(last_seen.last), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      tbl[0] = mk(10,  0, SEW32,  8, 16, 24, 0, 0, 3, 2, 4'b0011, 10);
      tbl[1] = mk(20,  0, SEW8,   8,  2,  3, 0, 0, 5, 4, 4'b1111,  9);
      tbl[2] = mk( 8,  6, SEW32,  8, 16, 24, 0, 0, 1, 1, 4'b1100,  9);
      tbl[3] = mk( 0,  0, SEW32,  8, 16, 24, 0, 0, 1, 0, 4'b0000,  8);
      tbl[4] = mk(16,  0, SEW16,  4, 12, 20, 1, 3, 4, 3, 4'b1111,  5);
      tbl[5] = mk(12,  0, SEW32, 30, 31,  0, 0, 0, 3, 2, 4'b1111,  0);
      tbl[6] = mk( 5,  9, SEW8,   7,  1,  2, 0, 0, 1, 2, 4'b0000,  7);

      repeat (2) @(posedge CLK);
      #1;
      check("rst_instr_ready", int'(instr_ready), 1);
      check("rst_uop_valid", int'(uop_valid), 0);
      check("rst_illegal", int'(illegal), 0);
      check("rst_outputs", int'({vuop_num, vuop_last, vlaneactive, vd_sel, vs1_sel, vs2_sel, vbank_offset}), 0);
      nRST = 1'b1;
      @(posedge CLK); #1;

      for (int i = 0; i < 7; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

      // Rejected element width: one-cycle illegal pulse, no uop.
      hs0 = hs_count;
      vl = 8'd8; vstart = '0; vsew = SEW64; instr_valid = 1'b1;
      @(posedge CLK); #1;
      instr_valid = 1'b0;
      check("illegal_pulse", int'(illegal), 1);
      check("illegal_no_uop", int'(uop_valid), 0);
      @(posedge CLK); #1;
      check("illegal_one_cycle", int'(illegal), 0);
      check("illegal_ready", int'(instr_ready), 1);
      repeat (3) @(posedge CLK);
      #1 check("illegal_hs_none", hs_count - hs0, 0);

      // Flush beats a legal instruction in IDLE.
      drive_instr(tbl[0]); flush = 1'b1;
      @(posedge CLK); #1;
      instr_valid = 1'b0; flush = 1'b0;
      check("flush_idle_no_accept", int'(uop_valid), 0);
      check("flush_idle_ready", int'(instr_ready), 1);

      // Flush while uop 1 is presented.
      push_model(tbl[0]);
      drive_instr(tbl[0]);
      @(posedge CLK); #1;
      instr_valid = 1'b0;
      @(posedge CLK); #1;
      check("flush_at_uop1_num", int'(vuop_num), 1);
      uop_ready = 1'b0; flush = 1'b1;
      @(posedge CLK); #1;
      flush = 1'b0;
      check("flush_uop_valid", int'(uop_valid), 0);
      check("flush_instr_ready", int'(instr_ready), 1);
      check("flush_illegal", int'(illegal), 0);
      check("flush_one_uop_done", exp_q.size(), 2);
      exp_q.delete();
      uop_ready = 1'b1;
      run_instr(tbl[0], "after_flush");

      // Asynchronous reset mid-instruction.
      uop_ready = 1'b0;
      drive_instr(tbl[2]);
      @(posedge CLK); #1;
      instr_valid = 1'b0;
      check("arst_pre_valid", int'(uop_valid), 1);
      #2 nRST = 1'b0;
      #1;
      check("arst_uop_valid", int'(uop_valid), 0);
      check("arst_instr_ready", int'(instr_ready), 1);
      check("arst_outputs", int'({vuop_num, vuop_last, vlaneactive, vd_sel, vs1_sel, vs2_sel, vbank_offset}), 0);
      @(posedge CLK); #1;
      nRST = 1'b1; uop_ready = 1'b1;
      run_instr(tbl[1], "after_arst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
